// File: rtl/alu_share_arbiter_if.sv
// Handshake bundle between the two ALU requesters, the shared ALU and the arbiter.
// The arbiter connects to the slave modport. Requesters and the ALU connect to the master modport.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             alu_en;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_data;
    logic             rsp0_err;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_data;
    logic             rsp1_err;
    logic             busy;
    logic [CNT_W-1:0] done_count;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_result, rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output alu_en, alu_op, alu_a, alu_b,
        output rsp0_valid, rsp0_data, rsp0_err,
        output rsp1_valid, rsp1_data, rsp1_err,
        output busy, done_count
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_result, rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  alu_en, alu_op, alu_a, alu_b,
        input  rsp0_valid, rsp0_data, rsp0_err,
        input  rsp1_valid, rsp1_data, rsp1_err,
        input  busy, done_count
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between the core pipeline (req0) and the debug unit (req1).
//   state | meaning
//   IDLE  | waiting for a request; grant goes to the one requester that is valid, or alternates when both are valid
//   ISSUE | operands driven to the ALU for one cycle; the result is captured at the end of the cycle
//   RESP  | response is held to the owner until that owner takes it
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               reset,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state, state_nxt;
    logic             last_grant;
    logic             owner;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] data_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic             grant;
    logic             take;
    logic             rsp_take;
    logic [3:0]       sel_op;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'b0001, 4'b0010, 4'b0011, 4'b0110,
            4'b0111, 4'b1001, 4'b1010: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    always_comb begin
        grant          = bus.req1_valid;
        state_nxt      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.alu_en     = 1'b0;
        bus.alu_op     = 4'b0000;
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.rsp0_err   = 1'b0;
        bus.rsp1_err   = 1'b0;
        bus.rsp0_data  = '0;
        bus.rsp1_data  = '0;
        bus.busy       = (state != IDLE);
        bus.done_count = cnt_q;
        // Both valid: the requester that did not win last time goes first.
        if (bus.req0_valid && bus.req1_valid)
            grant = ~last_grant;
        sel_op   = grant ? bus.req1_op : bus.req0_op;
        take     = 1'b0;
        rsp_take = 1'b0;
        case (state)
            IDLE: begin
                bus.req0_ready = bus.req0_valid && !grant;
                bus.req1_ready = bus.req1_valid && grant;
                take           = bus.req0_ready || bus.req1_ready;
                if (take)
                    state_nxt = is_legal(sel_op) ? ISSUE : RESP;
            end
            ISSUE: begin
                bus.alu_en = 1'b1;
                bus.alu_op = op_q;
                bus.alu_a  = a_q;
                bus.alu_b  = b_q;
                state_nxt  = RESP;
            end
            RESP: begin
                bus.rsp0_valid = !owner;
                bus.rsp1_valid = owner;
                bus.rsp0_err   = !owner && err_q;
                bus.rsp1_err   = owner && err_q;
                bus.rsp0_data  = owner ? '0 : data_q;
                bus.rsp1_data  = owner ? data_q : '0;
                rsp_take       = owner ? bus.rsp1_ready : bus.rsp0_ready;
                if (rsp_take)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_q       <= 4'b0000;
            a_q        <= '0;
            b_q        <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                owner      <= grant;
                last_grant <= grant;
                op_q       <= sel_op;
                a_q        <= grant ? bus.req1_a : bus.req0_a;
                b_q        <= grant ? bus.req1_b : bus.req0_b;
                err_q      <= !is_legal(sel_op);
                data_q     <= '0;
            end
            if (state == ISSUE)
                data_q <= bus.alu_result;
            if (rsp_take)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: directed vector table, hand sequences for multi-cycle cases, and a
// randomized phase checked every cycle against a transaction-level reference model.
module tb_alu_share_arbiter;
    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;
    int   exp_done;

    alu_share_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
    alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd1:    return a << b[4:0];
            4'd2:    return a - b;
            4'd3:    return a + b;
            4'd6:    return a ^ b;
            4'd7:    return a >> b[4:0];
            4'd9:    return a | b;
            4'd10:   return a & b;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    function automatic bit legal(input logic [3:0] op);
        return op inside {4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd9, 4'd10};
    endfunction

    always_comb bus.alu_result = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, tracked as "cycles left before the response".
    bit          m_busy = 1'b0;
    bit          m_owner = 1'b0;
    bit          m_last = 1'b1;
    bit          m_err = 1'b0;
    int          m_left = 0;
    int          m_count = 0;
    logic [3:0]  m_op = 4'd0;
    logic [31:0] m_a = '0, m_b = '0, m_data = '0;

    always @(negedge clk) begin
        bit e_r0, e_r1, e_en, e_v0, e_v1;
        e_r0 = !m_busy && bus.req0_valid && (!bus.req1_valid || m_last);
        e_r1 = !m_busy && bus.req1_valid && (!bus.req0_valid || !m_last);
        e_en = m_busy && m_left > 0;
        e_v0 = m_busy && m_left == 0 && !m_owner;
        e_v1 = m_busy && m_left == 0 && m_owner;
        if (mon_on) begin
            chk("req0_ready", bus.req0_ready, e_r0);
            chk("req1_ready", bus.req1_ready, e_r1);
            chk("alu_en", bus.alu_en, e_en);
            chk("alu_op", bus.alu_op, e_en ? m_op : 4'd0);
            chk("alu_a", bus.alu_a, e_en ? m_a : 32'd0);
            chk("alu_b", bus.alu_b, e_en ? m_b : 32'd0);
            chk("rsp0_valid", bus.rsp0_valid, e_v0);
            chk("rsp1_valid", bus.rsp1_valid, e_v1);
            chk("rsp0_err", bus.rsp0_err, e_v0 && m_err);
            chk("rsp1_err", bus.rsp1_err, e_v1 && m_err);
            chk("busy", bus.busy, m_busy);
            chk("done_count", bus.done_count, m_count);
            if (e_v0) chk("rsp0_data", bus.rsp0_data, m_data);
            if (e_v1) chk("rsp1_data", bus.rsp1_data, m_data);
        end
        if (reset) begin
            m_busy = 1'b0; m_last = 1'b1; m_count = 0; m_left = 0; m_owner = 1'b0;
        end else if (!m_busy) begin
            if (e_r0 || e_r1) begin
                m_owner = e_r1;
                m_op    = e_r1 ? bus.req1_op : bus.req0_op;
                m_a     = e_r1 ? bus.req1_a : bus.req0_a;
                m_b     = e_r1 ? bus.req1_b : bus.req0_b;
                m_last  = m_owner;
                m_busy  = 1'b1;
                m_err   = !legal(m_op);
                m_data  = m_err ? 32'd0 : alu_ref(m_op, m_a, m_b);
                m_left  = m_err ? 0 : 1;
            end
        end else if (m_left > 0) begin
            m_left--;
        end else if (m_owner ? bus.rsp1_ready : bus.rsp0_ready) begin
            m_busy  = 1'b0;
            m_count = (m_count + 1) % (1 << CNT_W);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input bit id);
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    task automatic drive(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    // Returns just after the edge that accepted the request.
    task automatic send(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(id, op, a, b);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) begin
                tick();
                drop(id);
                return;
            end
            tick();
        end
        chk("send_timeout", 1, 0);
        drop(id);
    endtask

    task automatic wait_rsp(input bit id, output int lat, output int en_cnt);
        lat = 0;
        en_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.alu_en) en_cnt++;
            if (id ? bus.rsp1_valid : bus.rsp0_valid) begin
                lat = i;
                return;
            end
        end
        chk("rsp_timeout", 1, 0);
    endtask

    task automatic reset_dut();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [3:0] rand_op();
        logic [3:0] ops [7] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd9, 4'd10};
        if ($urandom_range(0, 1) == 1) return ops[$urandom_range(0, 6)];
        return 4'($urandom_range(0, 15));
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vt [10];

    initial begin
        int lat, en_cnt;
        bit acc0, acc1;
        int grants [$];

        vt[0] = '{4'b0011, 32'd5,          32'd7,          32'd12,         1'b0};
        vt[1] = '{4'b0010, 32'd10,         32'd3,          32'd7,          1'b0};
        vt[2] = '{4'b0110, 32'h000000F0,   32'h000000FF,   32'h0000000F,   1'b0};
        vt[3] = '{4'b1010, 32'hFFFF0000,   32'h0F0F0F0F,   32'h0F0F0000,   1'b0};
        vt[4] = '{4'b0001, 32'd1,          32'd4,          32'd16,         1'b0};
        vt[5] = '{4'b0100, 32'd9,          32'd9,          32'd0,          1'b1};
        vt[6] = '{4'b0111, 32'h00000080,   32'd3,          32'h00000010,   1'b0};
        vt[7] = '{4'b1001, 32'h000000F0,   32'h0000000F,   32'h000000FF,   1'b0};
        vt[8] = '{4'b0000, 32'd1,          32'd2,          32'd0,          1'b1};
        vt[9] = '{4'b1111, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1};

        bus.req0_valid = 1'b0; bus.req0_op = 4'd0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 4'd0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        mon_on = 1'b1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done_count", bus.done_count, 0);
        chk("rst_rsp0_data", bus.rsp0_data, 0);
        chk("rst_alu_en", bus.alu_en, 0);
        tick();

        // Vector table, alternating requesters, responses always taken.
        exp_done = 0;
        foreach (vt[i]) begin
            send(1'(i % 2), vt[i].op, vt[i].a, vt[i].b);
            wait_rsp(1'(i % 2), lat, en_cnt);
            chk("vec_latency", lat, vt[i].err ? 1 : 2);
            chk("vec_alu_en_cycles", en_cnt, vt[i].err ? 0 : 1);
            chk("vec_data", (i % 2 == 1) ? bus.rsp1_data : bus.rsp0_data, vt[i].data);
            chk("vec_err", (i % 2 == 1) ? bus.rsp1_err : bus.rsp0_err, vt[i].err);
            tick();
            exp_done = (exp_done + 1) % 16;
            @(negedge clk);
            chk("vec_done_count", bus.done_count, exp_done);
            chk("vec_idle", bus.busy, 0);
            tick();
        end

        // Both requesters valid continuously after reset: grants alternate starting with req0.
        reset_dut();
        drive(1'b0, 4'b0010, 32'd10, 32'd3);
        drive(1'b1, 4'b0110, 32'h000000F0, 32'h000000FF);
        for (int c = 0; c < 60 && grants.size() < 6; c++) begin
            @(negedge clk);
            if (bus.req0_ready) grants.push_back(0);
            if (bus.req1_ready) grants.push_back(1);
            if (bus.rsp0_valid) chk("alt_rsp0_data", bus.rsp0_data, 32'd7);
            if (bus.rsp1_valid) chk("alt_rsp1_data", bus.rsp1_data, 32'h0000000F);
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("alt_grant_count", grants.size(), 6);
        foreach (grants[i]) chk("alt_grant_order", grants[i], i % 2);
        for (int c = 0; c < 10; c++) tick();

        // Backpressure: response held, other requester locked out, IDLE right after the take.
        bus.rsp0_ready = 1'b0;
        send(1'b0, 4'b1010, 32'hFFFF0000, 32'h0F0F0F0F);
        drive(1'b1, 4'b0011, 32'd1, 32'd2);
        wait_rsp(1'b0, lat, en_cnt);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_rsp0_valid", bus.rsp0_valid, 1);
            chk("bp_rsp0_data", bus.rsp0_data, 32'h0F0F0000);
            chk("bp_req1_ready", bus.req1_ready, 0);
        end
        tick();
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_until_take", bus.rsp0_valid, 1);
        tick();
        @(negedge clk);
        chk("bp_idle_after_take", bus.busy, 0);
        chk("bp_req1_ready_after", bus.req1_ready, 1);
        tick();
        drop(1'b1);
        wait_rsp(1'b1, lat, en_cnt);
        chk("bp_req1_data", bus.rsp1_data, 32'd3);
        tick();

        // Reset during ISSUE discards the transaction.
        reset_dut();
        send(1'b0, 4'b0001, 32'd1, 32'd4);
        reset = 1'b1;
        @(negedge clk);
        chk("rmid_in_issue", bus.alu_en, 1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rmid_alu_en", bus.alu_en, 0);
        chk("rmid_alu_op", bus.alu_op, 0);
        chk("rmid_alu_a", bus.alu_a, 0);
        chk("rmid_alu_b", bus.alu_b, 0);
        chk("rmid_rsp0_valid", bus.rsp0_valid, 0);
        chk("rmid_rsp0_data", bus.rsp0_data, 0);
        chk("rmid_rsp0_err", bus.rsp0_err, 0);
        chk("rmid_busy", bus.busy, 0);
        chk("rmid_done_count", bus.done_count, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rmid_no_rsp", bus.rsp0_valid, 0);
        end
        tick();
        drive(1'b0, 4'b0011, 32'd2, 32'd2);
        drive(1'b1, 4'b0011, 32'd3, 32'd3);
        @(negedge clk);
        chk("rmid_first_req0", bus.req0_ready, 1);
        chk("rmid_first_req1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_rsp(1'b0, lat, en_cnt);
        chk("rmid_after_data", bus.rsp0_data, 32'd4);
        tick();

        // done_count wraps after 2^CNT_W + 1 completions.
        reset_dut();
        for (int n = 0; n < 17; n++) begin
            send(1'b0, 4'b0011, 32'(n), 32'd1);
            wait_rsp(1'b0, lat, en_cnt);
        end
        tick();
        @(negedge clk);
        chk("wrap_done_count", bus.done_count, 1);
        tick();

        // Randomized traffic with backpressure and occasional resets.
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            acc0 = bus.req0_valid && bus.req0_ready;
            acc1 = bus.req1_valid && bus.req1_ready;
            tick();
            if (acc0 || reset) bus.req0_valid = 1'b0;
            if (acc1 || reset) bus.req1_valid = 1'b0;
            reset = ($urandom_range(0, 99) == 0);
            if (!bus.req0_valid && $urandom_range(0, 2) == 0)
                drive(1'b0, rand_op(), $urandom, $urandom);
            if (!bus.req1_valid && $urandom_range(0, 2) == 0)
                drive(1'b1, rand_op(), $urandom, $urandom);
            bus.rsp0_ready = ($urandom_range(0, 3) != 0);
            bus.rsp1_ready = ($urandom_range(0, 3) != 0);
        end
        reset = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        @(negedge clk);
        chk("final_idle", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single ALU datapath (4-bit ALU control code, two WIDTH-bit operands, combinational result) between two requesters: req0 (core pipeline) and req1 (auxiliary/debug unit).
- Round-robin arbitration with valid/ready handshakes on request and response channels.
- Rejects undefined ALU control codes without driving the ALU.
- Sits between the requesters and the ALU. The ALU control decoder feeds req0_op.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  arbiter accepts req0 this cycle.
- req0_op  in  4  ALU control code.
- req0_a  in  WIDTH  operand A.
- req0_b  in  WIDTH  operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as req0, for requester 1.
- alu_en  out  1  ALU operands valid this cycle.
- alu_op  out  4  ALU control code to ALU.
- alu_a  out  WIDTH  operand A to ALU.
- alu_b  out  WIDTH  operand B to ALU.
- alu_result  in  WIDTH  combinational ALU result.
- rsp0_valid  out  1  response for requester 0.
- rsp0_ready  in  1  requester 0 takes response.
- rsp0_data  out  WIDTH  result.
- rsp0_err  out  1  illegal op code.
- rsp1_valid, rsp1_ready, rsp1_data, rsp1_err: same as rsp0, for requester 1.
- busy  out  1  state != IDLE.
- done_count  out  CNT_W  completed responses, both requesters.

Behaviour:
- Legal op codes: 0001 SLL, 0010 SUB, 0011 ADD, 0110 XOR, 0111 SRL, 1001 OR, 1010 AND. All other codes are illegal.
- FSM states: IDLE, ISSUE, RESP.
- Reset (sync, active-high):
  - state = IDLE, last_grant = 1, so req0 wins the first tie.
  - All rsp*_valid/err = 0, rsp*_data = 0.
  - alu_en = 0, alu_op = 0000, alu_a = alu_b = 0.
  - done_count = 0, busy = 0.
- IDLE, grant selection:
  - Only one valid: grant that requester.
  - Both valid: grant !last_grant.
- IDLE, ready and transfer:
  - reqN_ready = (state==IDLE) && grant==N. It is combinational from valid and last_grant.
  - At most one ready is high per cycle.
  - On transfer (valid && ready): latch op, a, b and the owner id; set last_grant = owner.
  - Next state: ISSUE if op is legal; RESP with err=1, data=0 if illegal.
- ISSUE (exactly 1 cycle):
  - alu_en = 1; alu_op/a/b driven from the latched registers.
  - alu_result is captured into the response data register at the clock edge; next state RESP.
- Outside ISSUE: alu_en = 0, alu_op = 0000, alu_a = alu_b = 0.
- RESP:
  - rspN_valid = 1 for the owner only; data and err are held stable until rspN_ready.
  - On rspN_ready: valid drops next cycle, done_count increments (wraps at 2^CNT_W), state returns to IDLE.
  - Illegal-op responses also count.
- Latency:
  - Legal op accepted at edge N: rsp_valid is high in cycle N+2.
  - Illegal op: rsp_valid is high in cycle N+1.
  - With rsp_ready tied high, minimum spacing is 3 cycles per legal op.
- No request is accepted while busy. Requesters must hold valid and payload stable until ready.
- Non-owner rsp_ready is ignored.
- Reset mid-operation: the in-flight transaction is discarded, no response is produced, and all outputs return to reset values on the next cycle.
- The response channel holds indefinitely under backpressure. ALU outputs stay zero during RESP.

Test Plan:
- Reset, then req0: op=0011, a=5, b=7, rsp0_ready=1 -> alu_en high exactly one cycle with alu_op=0011; rsp0_valid 2 cycles after accept; rsp0_data=12, rsp0_err=0; done_count=1.
- Both requesters valid continuously after reset: req0 SUB a=10,b=3; req1 XOR a=0xF0,b=0xFF -> grants alternate req0, req1, req0, ...; responses rsp0_data=7 and rsp1_data=0x0F; rsp1_valid never high for req0's ops.
- req1 op=0100 (illegal) -> alu_en stays 0; rsp1_valid 1 cycle after accept with rsp1_err=1, rsp1_data=0; done_count increments.
- req0 AND a=0xFFFF0000, b=0x0F0F0F0F with rsp0_ready held low for 5 cycles -> rsp0_valid and rsp0_data=0x0F0F0000 stable for all 5 cycles; req1_ready stays 0 throughout; IDLE resumes the cycle after rsp0_ready.
- Assert reset during ISSUE of req0 SLL a=1, b=4 -> no rsp0_valid ever; next cycle all outputs are at reset values; a following simultaneous req0/req1 pair grants req0 first.
- Run 2^CNT_W+1 legal ops (CNT_W overridden to 4) -> done_count wraps to 1.
